// File: rtl/cim_ctrl_pkg.sv
// Shared definitions for the CIM matmul sequencer: opcodes, FSM states, defaults.
package cim_ctrl_pkg;

  localparam int DEFAULT_CIM_LAT = 1;
  localparam int DEFAULT_LEN_W   = 8;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_MAC   = 2'd2,
    OP_RSVD  = 2'd3
  } cim_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_MAC    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_RESULT = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/cim_addr_gen.sv
// Beat counter and row-address generator for LOAD/MAC streams.
// Captures the command's base row and length when a command is accepted;
// the address is base + beat index with natural 32-bit wrap.
module cim_addr_gen
  import cim_ctrl_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             start,
  input  logic             step,
  input  logic [31:0]      start_addr,
  input  logic [LEN_W-1:0] start_len,
  output logic [31:0]      beat_addr,
  output logic             first_beat,
  output logic             last_beat
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;

  // Latch base/length on a new command, then count accepted beats
  always_ff @(posedge CLK) begin
    if (RES) begin
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      base_q  <= start_addr;
      len_q   <= start_len;
      count_q <= '0;
    end else if (step) begin
      count_q <= count_q + ONE;
    end
  end

  assign beat_addr  = base_q + 32'(count_q);
  assign first_beat = (count_q == '0);
  assign last_beat  = (count_q == (len_q - ONE));

endmodule

// File: rtl/cim_matmul_sequencer.sv
// Command sequencer driving a compute-in-memory macro: CLEAR of an output
// register, LOAD of weight rows and MAC streams with result readback.
// All CIM-side outputs are registered, so an accepted beat shows up on the
// macro port one cycle later.
module cim_matmul_sequencer
  import cim_ctrl_pkg::*;
#(
  parameter int CIM_LAT = DEFAULT_CIM_LAT,
  parameter int LEN_W   = DEFAULT_LEN_W
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cmd_oreg,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [31:0]      data_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [31:0]      result_data,
  output logic             busy,
  output logic             done,
  output logic             write,
  output logic             cim,
  output logic             partial_sum,
  output logic             reset_output,
  output logic [3:0]       output_reg,
  output logic [31:0]      address,
  output logic [31:0]      input_data,
  input  logic [31:0]      cim_output
);

  seq_state_e  state;
  logic [3:0]  oreg_q;
  logic [7:0]  drain_cnt;

  logic        cmd_accept;
  logic        beat_accept;
  logic [31:0] gen_addr;
  logic        gen_first;
  logic        gen_last;

  assign cmd_accept  = (state == ST_IDLE) && cmd_valid;
  assign beat_accept = data_ready && data_valid;

  cim_addr_gen #(
    .LEN_W(LEN_W)
  ) u_addr_gen (
    .CLK        (CLK),
    .RES        (RES),
    .start      (cmd_accept),
    .step       (beat_accept),
    .start_addr (cmd_addr),
    .start_len  (cmd_len),
    .beat_addr  (gen_addr),
    .first_beat (gen_first),
    .last_beat  (gen_last)
  );

  // Sequencer FSM; strobes default low each cycle and are raised only on work cycles
  always_ff @(posedge CLK) begin
    if (RES) begin
      state        <= ST_IDLE;
      oreg_q       <= '0;
      drain_cnt    <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      data_ready   <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      write        <= 1'b0;
      cim          <= 1'b0;
      partial_sum  <= 1'b0;
      reset_output <= 1'b0;
      output_reg   <= '0;
      address      <= '0;
      input_data   <= '0;
    end else begin
      write        <= 1'b0;
      cim          <= 1'b0;
      partial_sum  <= 1'b0;
      reset_output <= 1'b0;
      output_reg   <= '0;
      done         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            oreg_q    <= cmd_oreg;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cim_op_e'(cmd_op))
              OP_CLEAR: begin
                state        <= ST_CLEAR;
                reset_output <= 1'b1;
                output_reg   <= cmd_oreg;
              end
              OP_LOAD: begin
                if (cmd_len == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state      <= ST_LOAD;
                  data_ready <= 1'b1;
                end
              end
              OP_MAC: begin
                if (cmd_len == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state      <= ST_MAC;
                  data_ready <= 1'b1;
                end
              end
              default: begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end

        ST_CLEAR: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end

        ST_LOAD: begin
          if (beat_accept) begin
            write      <= 1'b1;
            address    <= gen_addr;
            input_data <= data_in;
            if (gen_last) begin
              data_ready <= 1'b0;
            end
          end else if (!data_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end

        ST_MAC: begin
          if (beat_accept) begin
            cim         <= 1'b1;
            partial_sum <= !gen_first;
            output_reg  <= oreg_q;
            address     <= gen_addr;
            input_data  <= data_in;
            if (gen_last) begin
              data_ready <= 1'b0;
            end
          end else if (!data_ready) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == 8'(CIM_LAT - 1)) begin
            result_data  <= cim_output;
            result_valid <= 1'b1;
            state        <= ST_RESULT;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end

        ST_RESULT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= ST_DONE;
            done         <= 1'b1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_matmul_sequencer.sv
// Self-checking bench for cim_matmul_sequencer: per-command expected cycle
// timelines derived from the command rules, a small CIM macro model, and
// directed literal checks for the corner cases.
module tb_cim_matmul_sequencer;

  localparam int LAT   = 2;
  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RES;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [3:0]       cmd_oreg;
  logic             data_valid;
  logic             data_ready;
  logic [31:0]      data_in;
  logic             result_valid;
  logic             result_ready;
  logic [31:0]      result_data;
  logic             busy;
  logic             done;
  logic             write;
  logic             cim;
  logic             partial_sum;
  logic             reset_output;
  logic [3:0]       output_reg;
  logic [31:0]      address;
  logic [31:0]      input_data;
  logic [31:0]      cim_output;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          busy;
    bit          cmd_ready;
    bit          data_ready;
    bit          write;
    bit          cim;
    bit          ps;
    bit          rst_o;
    bit          rvalid;
    bit          done;
    logic [3:0]  oreg;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_cur;
  bit          exp_en = 1'b0;
  logic [31:0] user_data [$];
  logic [31:0] seen_addr [$];
  logic [31:0] seen_din  [$];
  bit          seen_ps   [$];
  logic [3:0]  seen_oreg [$];
  int          seen_rst;
  logic [31:0] seen_rdata;

  bit          cim_force;
  logic [31:0] cim_force_val;
  logic [31:0] acc_q;
  logic [31:0] pipe [LAT];

  cim_matmul_sequencer #(
    .CIM_LAT (LAT),
    .LEN_W   (LEN_W)
  ) dut (
    .CLK          (CLK),
    .RES          (RES),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_oreg     (cmd_oreg),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_in      (data_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .busy         (busy),
    .done         (done),
    .write        (write),
    .cim          (cim),
    .partial_sum  (partial_sum),
    .reset_output (reset_output),
    .output_reg   (output_reg),
    .address      (address),
    .input_data   (input_data),
    .cim_output   (cim_output)
  );

  always #5 CLK = ~CLK;

  // CIM macro model: accumulates strobed inputs, result visible LAT cycles after the strobe
  function automatic logic [31:0] acc_next();
    if (cim) return partial_sum ? acc_q + input_data : input_data;
    return acc_q;
  endfunction

  always @(posedge CLK) begin
    acc_q   <= acc_next();
    pipe[0] <= acc_next();
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign cim_output = cim_force ? cim_force_val : pipe[LAT-1];

  function automatic exp_t mk_idle();
    exp_t e;
    e = '{default: '0};
    e.cmd_ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_busy();
    exp_t e;
    e = '{default: '0};
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_output();
    cmp("busy",         32'(busy),         32'(exp_cur.busy));
    cmp("cmd_ready",    32'(cmd_ready),    32'(exp_cur.cmd_ready));
    cmp("data_ready",   32'(data_ready),   32'(exp_cur.data_ready));
    cmp("write",        32'(write),        32'(exp_cur.write));
    cmp("cim",          32'(cim),          32'(exp_cur.cim));
    cmp("reset_output", 32'(reset_output), 32'(exp_cur.rst_o));
    cmp("result_valid", 32'(result_valid), 32'(exp_cur.rvalid));
    cmp("done",         32'(done),         32'(exp_cur.done));
    if (exp_cur.write || exp_cur.cim) begin
      cmp("address",    address,    exp_cur.addr);
      cmp("input_data", input_data, exp_cur.din);
    end
    if (exp_cur.cim) begin
      cmp("partial_sum", 32'(partial_sum), 32'(exp_cur.ps));
    end
    if (exp_cur.cim || exp_cur.rst_o) begin
      cmp("output_reg", 32'(output_reg), 32'(exp_cur.oreg));
    end
    if (exp_cur.rvalid) begin
      cmp("result_data", result_data, exp_cur.rdata);
    end
    if (write || cim) begin
      seen_addr.push_back(address);
      seen_din.push_back(input_data);
    end
    if (cim) seen_ps.push_back(partial_sum);
    if (cim || reset_output) seen_oreg.push_back(output_reg);
    if (reset_output) seen_rst++;
    if (result_valid) seen_rdata = result_data;
  endtask

  // Single compare process, sampling mid-cycle
  always @(negedge CLK) begin
    if (exp_en) check_output();
  end

  task automatic clear_seen();
    seen_addr.delete();
    seen_din.delete();
    seen_ps.delete();
    seen_oreg.delete();
    seen_rst   = 0;
    seen_rdata = '0;
  endtask

  // Build the expected timeline for one command, then drive it cycle by cycle
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] base, input int len,
                                input logic [3:0] oreg, input int max_gap, input int gap_idx,
                                input int gap_len, input int rd, input int abort_at);
    exp_t        tl  [$];
    bit          dvq [$];
    logic [31:0] dq  [$];
    bit          rrq [$];
    int          c   [];
    logic [31:0] d   [];
    logic [31:0] sum;
    logic [31:0] res;
    exp_t        e;
    int          last;
    int          bi;
    int          si;
    sum = '0;
    if (op == 2'd0) begin
      e = mk_busy(); e.rst_o = 1'b1; e.oreg = oreg;
      tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(1'($urandom));
      e = mk_busy(); e.done = 1'b1;
      tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(1'($urandom));
    end else if (op == 2'd3 || len == 0) begin
      e = mk_busy(); e.done = 1'b1;
      tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(1'($urandom));
    end else begin
      c = new[len];
      d = new[len];
      for (int i = 0; i < len; i++) begin
        int g;
        g = (i == gap_idx) ? gap_len : int'($urandom_range(0, max_gap));
        c[i] = (i == 0) ? g : c[i-1] + 1 + g;
        d[i] = (i < user_data.size()) ? user_data[i] : $urandom;
        sum += d[i];
      end
      last = c[len-1];
      bi = 0;
      si = 0;
      for (int k = 0; k <= last + 1; k++) begin
        e = mk_busy();
        e.data_ready = (k <= last);
        if (si < len && c[si] + 1 == k) begin
          if (op == 2'd1) begin
            e.write = 1'b1;
          end else begin
            e.cim  = 1'b1;
            e.ps   = (si > 0);
            e.oreg = oreg;
          end
          e.addr = base + 32'(si);
          e.din  = d[si];
          si++;
        end
        tl.push_back(e);
        if (bi < len && c[bi] == k) begin
          dvq.push_back(1'b1); dq.push_back(d[bi]); bi++;
        end else begin
          dvq.push_back((k > last) ? 1'($urandom) : 1'b0); dq.push_back($urandom);
        end
        rrq.push_back(1'($urandom));
      end
      if (op == 2'd2) begin
        res = cim_force ? cim_force_val : sum;
        for (int j = 0; j < LAT; j++) begin
          e = mk_busy();
          tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(1'($urandom));
        end
        for (int j = 0; j <= rd; j++) begin
          e = mk_busy(); e.rvalid = 1'b1; e.rdata = res;
          tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(j == rd);
        end
      end
      e = mk_busy(); e.done = 1'b1;
      tl.push_back(e); dvq.push_back(1'($urandom)); dq.push_back($urandom); rrq.push_back(1'($urandom));
    end

    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_addr     = base;
    cmd_len      = LEN_W'(len);
    cmd_oreg     = oreg;
    data_valid   = 1'($urandom);
    data_in      = $urandom;
    result_ready = 1'($urandom);
    exp_cur      = mk_idle();
    @(posedge CLK); #1;
    for (int k = 0; k < tl.size(); k++) begin
      cmd_valid    = 1'($urandom);
      cmd_op       = 2'($urandom);
      cmd_addr     = $urandom;
      cmd_len      = LEN_W'($urandom);
      cmd_oreg     = 4'($urandom);
      data_valid   = dvq[k];
      data_in      = dq[k];
      result_ready = rrq[k];
      exp_cur      = tl[k];
      if (k == abort_at) RES = 1'b1;
      @(posedge CLK); #1;
      if (k == abort_at) begin
        RES = 1'b0;
        break;
      end
    end
    cmd_valid    = 1'b0;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    exp_cur      = mk_idle();
  endtask

  task automatic check_reset_values();
    @(negedge CLK);
    cmp("rst output_reg",  32'(output_reg), 32'h0);
    cmp("rst address",     address,         32'h0);
    cmp("rst input_data",  input_data,      32'h0);
    cmp("rst result_data", result_data,     32'h0);
    cmp("rst partial_sum", 32'(partial_sum), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RES = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_oreg = '0;
    data_valid = 1'b0; data_in = '0; result_ready = 1'b0;
    cim_force = 1'b0; cim_force_val = '0;
    exp_cur = mk_idle();
    clear_seen();
    repeat (3) @(posedge CLK);
    #1;
    RES = 1'b0;
    exp_en = 1'b1;
    check_reset_values();
    @(posedge CLK); #1;

    // CLEAR of output register 3
    clear_seen();
    apply_stimulus(2'd0, 32'h0, 0, 4'd3, 0, -1, 0, 0, -1);
    cmp("clear pulses", 32'(seen_rst), 32'd1);
    cmp("clear oreg", 32'(seen_oreg[0]), 32'd3);

    // LOAD three rows from 0x10
    clear_seen();
    user_data = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    apply_stimulus(2'd1, 32'h10, 3, 4'd0, 1, -1, 0, 0, -1);
    user_data.delete();
    cmp("load count", 32'(seen_addr.size()), 32'd3);
    cmp("load addr0", seen_addr[0], 32'h10);
    cmp("load addr1", seen_addr[1], 32'h11);
    cmp("load addr2", seen_addr[2], 32'h12);
    cmp("load data2", seen_din[2], 32'hC0C0_0003);

    // MAC of four beats with a two-cycle stall after beat 1; macro forced to 0x55
    clear_seen();
    cim_force = 1'b1; cim_force_val = 32'h55;
    apply_stimulus(2'd2, 32'h0, 4, 4'd2, 0, 2, 2, 2, -1);
    cim_force = 1'b0;
    cmp("mac strobes", 32'(seen_ps.size()), 32'd4);
    cmp("mac ps0", 32'(seen_ps[0]), 32'd0);
    cmp("mac ps1", 32'(seen_ps[1]), 32'd1);
    cmp("mac ps3", 32'(seen_ps[3]), 32'd1);
    cmp("mac oreg", 32'(seen_oreg[0]), 32'd2);
    cmp("mac result", seen_rdata, 32'h55);

    // LOAD across the top of the address space
    clear_seen();
    apply_stimulus(2'd1, 32'hFFFF_FFFF, 2, 4'd0, 1, -1, 0, 0, -1);
    cmp("wrap addr0", seen_addr[0], 32'hFFFF_FFFF);
    cmp("wrap addr1", seen_addr[1], 32'h0000_0000);

    // Zero-length MAC and reserved opcode
    clear_seen();
    apply_stimulus(2'd2, 32'h40, 0, 4'd1, 0, -1, 0, 0, -1);
    apply_stimulus(2'd3, 32'h40, 5, 4'd1, 0, -1, 0, 0, -1);
    cmp("len0 strobes", 32'(seen_addr.size()), 32'd0);

    // Reset during MAC beat 2: back to idle with no done and no result
    clear_seen();
    apply_stimulus(2'd2, 32'h100, 4, 4'd5, 0, -1, 0, 0, 3);
    check_reset_values();
    repeat (4) @(posedge CLK);
    #1;

    // Randomized command mix
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [31:0] base;
      op   = 2'($urandom_range(0, 3));
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      apply_stimulus(op, base, int'($urandom_range(0, 6)), 4'($urandom), 2, -1, 0,
                     int'($urandom_range(0, 3)), -1);
    end

    repeat (2) @(posedge CLK);
    #1;
    exp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
